// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel shadow/active duty registers.
// Define PWM_CENTER_ALIGN_EN for a center-aligned up/down counter; the default build is edge-aligned.
module pwm_multi #(
    parameter int  WIDTH    = 10,
    parameter int  CHANNELS = 4,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                duty_wr,
    input  logic [CW-1:0]       wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    output logic [CHANNELS-1:0] PWM_sig,
    output logic                period_start
);

    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [CW:0]      CH_LIM = (CW+1)'(CHANNELS);

    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic                wr_ok;
    logic                load;
    logic [CHANNELS-1:0] cmp;

    assign wr_ok = duty_wr && ({1'b0, wr_ch} < CH_LIM);

`ifdef PWM_CENTER_ALIGN_EN
    logic down;

    // Loading on the last down-count step makes the new duty take effect exactly at cnt==0.
    assign load = !enable || (down && (cnt == WIDTH'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            down <= 1'b0;
        end else if (!enable) begin
            cnt  <= '0;
            down <= 1'b0;
        end else if (!down) begin
            if (cnt == MAX) begin
                down <= 1'b1;
                cnt  <= cnt - WIDTH'(1);
            end else begin
                cnt  <= cnt + WIDTH'(1);
            end
        end else begin
            if (cnt == WIDTH'(1)) begin
                down <= 1'b0;
            end
            cnt <= cnt - WIDTH'(1);
        end
    end
`else
    assign load = !enable || (cnt == MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end
`endif

    // Active takes the shadow value seen before this edge, so a write on the load edge lands one period later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_ok && (wr_ch == CW'(i))) begin
                    shadow[i] <= wr_duty;
                end
                if (load) begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cmp[i] = enable && (cnt < active[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PWM_sig      <= '0;
            period_start <= 1'b0;
        end else begin
            PWM_sig      <= cmp;
            period_start <= enable && (cnt == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi (edge-aligned build): a period-level reference model pushes the expected duty
// vector of each period; a monitor measures high time, contiguity and length of every complete period.
module tb_pwm_multi;

    localparam int WIDTH    = 10;
    localparam int CHANNELS = 5;
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PERIOD   = 1 << WIDTH;
    localparam int MAX      = PERIOD - 1;
    localparam int DW       = CHANNELS * WIDTH;

    logic                clk;
    logic                rst;
    logic                enable;
    logic                duty_wr;
    logic [CW-1:0]       wr_ch;
    logic [WIDTH-1:0]    wr_duty;
    logic [CHANNELS-1:0] PWM_sig;
    logic                period_start;

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .duty_wr      (duty_wr),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .PWM_sig      (PWM_sig),
        .period_start (period_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] exp_q[$];

    // Reference model state: programmed duties, the duty vector latched for the next period, period position.
    int            shadow_m [CHANNELS];
    logic [DW-1:0] snap_m;
    int            cnt_m;
    bit            cut;

    // Monitor state for the period currently being measured.
    bit            open_p;
    logic [DW-1:0] cur_exp;
    int            len_p;
    int            hi   [CHANNELS];
    bit            fell [CHANNELS];
    bit            bad  [CHANNELS];

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endfunction

    function automatic logic [DW-1:0] pack_shadow();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < CHANNELS; i++) v[i*WIDTH +: WIDTH] = WIDTH'(shadow_m[i]);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < CHANNELS; i++) shadow_m[i] = 0;
        snap_m = '0;
        cnt_m  = 0;
    endfunction

    function automatic int rand_duty();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 0;
        if (r == 1) return MAX;
        return $urandom_range(0, MAX);
    endfunction

    // One clock: apply inputs, advance the model by the period rules, release the strobe.
    task automatic step(input bit wr, input int ch, input int val);
        duty_wr = wr;
        wr_ch   = CW'(ch);
        wr_duty = WIDTH'(val);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!enable) begin
                snap_m = pack_shadow();
                cnt_m  = 0;
            end else begin
                if (cnt_m == MAX) snap_m = pack_shadow();
                if (cnt_m == 0) exp_q.push_back(snap_m);
                cnt_m = (cnt_m + 1) % PERIOD;
            end
            if (wr && ch < CHANNELS) shadow_m[ch] = val;
        end
        #1;
        duty_wr = 1'b0;
    endtask

    task automatic run_to(input int c);
        for (int k = 0; k <= PERIOD && cnt_m != c; k++) step(1'b0, 0, 0);
    endtask

    task automatic run_periods(input int n);
        repeat (n * PERIOD) step(1'b0, 0, 0);
    endtask

    task automatic finalize();
        for (int i = 0; i < CHANNELS; i++) begin
            check($sformatf("ch%0d_high_cycles", i), hi[i], int'(cur_exp[i*WIDTH +: WIDTH]));
            check($sformatf("ch%0d_single_pulse_from_start", i), int'(bad[i]), 0);
        end
        check("period_length", len_p, PERIOD);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (cut) begin
                cut    = 1'b0;
                open_p = 1'b0;
            end else if (period_start) begin
                if (open_p) finalize();
                check("period_start_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    cur_exp = exp_q.pop_front();
                    open_p  = 1'b1;
                    len_p   = 0;
                    for (int i = 0; i < CHANNELS; i++) begin
                        hi[i]   = 0;
                        fell[i] = 1'b0;
                        bad[i]  = 1'b0;
                    end
                end else begin
                    open_p = 1'b0;
                end
            end else if (!open_p) begin
                check("idle_pwm_sig", int'(PWM_sig), 0);
            end
            if (open_p) begin
                len_p++;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (PWM_sig[i]) begin
                        if (fell[i]) bad[i] = 1'b1;
                        hi[i]++;
                    end else begin
                        fell[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic driver();
        rst     = 1'b1;
        enable  = 1'b0;
        duty_wr = 1'b0;
        wr_ch   = '0;
        wr_duty = '0;
        cut     = 1'b0;
        open_p  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pwm_sig", int'(PWM_sig), 0);
        check("reset_period_start", int'(period_start), 0);
        rst = 1'b0;

        // Single duty on ch0 programmed while idle.
        step(1'b1, 0, 5);
        step(1'b0, 0, 0);
        enable = 1'b1;
        run_periods(3);

        // Mid-period update on ch1.
        run_to(500);
        step(1'b1, 1, 100);
        run_to(200);
        step(1'b1, 1, 300);
        run_periods(2);

        // Write landing on the load edge.
        run_to(300);
        step(1'b1, 2, 10);
        run_to(MAX);
        step(1'b1, 2, 50);
        run_periods(3);

        // Boundary duties.
        step(1'b1, 0, 0);
        step(1'b1, 1, MAX);
        step(1'b1, 3, 1);
        run_periods(2);

        // Invalid channels must not disturb anything.
        step(1'b1, 5, 777);
        step(1'b1, 6, 333);
        step(1'b1, 7, 1);
        run_periods(2);

        // Randomized writes at random period positions, valid and invalid channels.
        repeat (6) begin
            run_to($urandom_range(0, MAX));
            step(1'b1, $urandom_range(0, 7), rand_duty());
        end
        run_periods(2);

        // Drop enable mid-period, program while idle, re-enable.
        run_to(2);
        enable = 1'b0;
        cut    = 1'b1;
        step(1'b0, 0, 0);
        check("disable_clears_pwm_sig", int'(PWM_sig), 0);
        check("disable_clears_period_start", int'(period_start), 0);
        step(1'b1, 0, 7);
        step(1'b1, 1, MAX);
        step(1'b1, 4, $urandom_range(1, MAX - 1));
        step(1'b0, 0, 0);
        enable = 1'b1;
        run_periods(2);

        // Asynchronous reset while ch1 is high.
        run_to(3);
        check("pre_reset_ch1_high", int'(PWM_sig[1]), 1);
        #1;
        rst = 1'b1;
        model_reset();
        cut = 1'b1;
        #1;
        check("async_reset_pwm_sig", int'(PWM_sig), 0);
        check("async_reset_period_start", int'(period_start), 0);
        step(1'b0, 0, 0);
        step(1'b0, 0, 0);
        rst = 1'b0;
        run_to(400);
        step(1'b1, 4, 600);
        run_periods(2);

        enable = 1'b0;
        cut    = 1'b1;
        repeat (3) step(1'b0, 0, 0);
        check("expected_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        fork
            driver();
            monitor();
        join_any
        disable fork;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
